// File: rtl/wb_sdram_bist_if.sv
// rtl/wb_sdram_bist_if.sv - Wishbone bus bundle between the SDRAM BIST master and the memory slave
interface wb_sdram_bist_if #(
   parameter int dw     = 32,
   parameter int APP_AW = 26
);
   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic              wb_we_o;
   logic [APP_AW-1:0] wb_addr_o;
   logic [dw-1:0]     wb_dat_o;
   logic [dw/8-1:0]   wb_sel_o;
   logic [2:0]        wb_cti_o;
   logic              wb_ack_i;
   logic [dw-1:0]     wb_dat_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
      input  wb_ack_i, wb_dat_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
      output wb_ack_i, wb_dat_i
   );
endinterface

// File: rtl/wb_sdram_bist.sv
// rtl/wb_sdram_bist.sv - Wishbone SDRAM write/read-back BIST engine
// Writes a pattern over a word range in bursts, reads it back and counts mismatches.
module wb_sdram_bist #(
   parameter int dw        = 32,
   parameter int APP_AW    = 26,
   parameter int BURST_LEN = 8,
   parameter int CNT_W     = 16,
   parameter int TIMEOUT   = 1024
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              sdr_init_done,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [dw-1:0]     seed,
   input  logic [APP_AW-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   wb_sdram_bist_if.master   wb,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  err_count,
   output logic [APP_AW-1:0] first_err_addr
);
   localparam int               BYTES   = dw / 8;
   localparam int               TW      = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] BMASK   = CNT_W'(BURST_LEN - 1);
   localparam logic [2:0]       CTI_INC = 3'b010;
   localparam logic [2:0]       CTI_END = 3'b111;

   typedef enum logic [2:0] {IDLE, WAIT_INIT, WRITE, WGAP, READ, RGAP, DONE} state_t;

   state_t            r_state;
   logic [1:0]        r_mode;
   logic [dw-1:0]     r_seed;
   logic [APP_AW-1:0] r_base, r_addr, r_wb_addr, r_first;
   logic [CNT_W-1:0]  r_count, r_idx, r_err;
   logic [TW-1:0]     r_tmo;
   logic              r_cyc, r_we, r_busy, r_done, r_pass, r_tmo_err;
   logic [dw-1:0]     r_dat;
   logic [dw/8-1:0]   r_sel;
   logic [2:0]        r_cti;

   function automatic logic [dw-1:0] f_pattern(input logic [1:0] m, input logic [dw-1:0] s,
                                               input logic [APP_AW-1:0] a, input logic [CNT_W-1:0] i);
      logic [dw-1:0] w_a;
      w_a = dw'(a);
      case (m)
         2'd0:    return w_a;
         2'd1:    return ~w_a;
         2'd2:    return dw'(1) << (i % CNT_W'(dw));
         default: return s + dw'(i);
      endcase
   endfunction

   function automatic logic [2:0] f_cti(input logic [CNT_W-1:0] i, input logic [CNT_W-1:0] last);
      return (((i & BMASK) == BMASK) || (i == last)) ? CTI_END : CTI_INC;
   endfunction

   logic [CNT_W-1:0]  w_last_idx, w_nxt_idx, w_err_nxt;
   logic [APP_AW-1:0] w_nxt_addr;
   logic [dw-1:0]     w_cur_dat, w_nxt_dat;
   logic [2:0]        w_cur_cti, w_nxt_cti;
   logic              w_final, w_mismatch;

   assign w_last_idx = r_count - CNT_W'(1);
   assign w_nxt_idx  = r_idx + CNT_W'(1);
   assign w_nxt_addr = r_addr + APP_AW'(BYTES);
   assign w_cur_dat  = f_pattern(r_mode, r_seed, r_addr, r_idx);
   assign w_nxt_dat  = f_pattern(r_mode, r_seed, w_nxt_addr, w_nxt_idx);
   assign w_cur_cti  = f_cti(r_idx, w_last_idx);
   assign w_nxt_cti  = f_cti(w_nxt_idx, w_last_idx);
   assign w_final    = (r_idx == w_last_idx);
   assign w_mismatch = (wb.wb_dat_i != w_cur_dat);
   assign w_err_nxt  = (w_mismatch && (r_err != '1)) ? r_err + CNT_W'(1) : r_err;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state   <= IDLE;
         r_mode    <= '0;
         r_seed    <= '0;
         r_base    <= '0;
         r_addr    <= '0;
         r_count   <= '0;
         r_idx     <= '0;
         r_tmo     <= '0;
         r_cyc     <= 1'b0;
         r_we      <= 1'b0;
         r_wb_addr <= '0;
         r_dat     <= '0;
         r_sel     <= '0;
         r_cti     <= 3'b000;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_tmo_err <= 1'b0;
         r_err     <= '0;
         r_first   <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_mode    <= mode;
                  r_seed    <= seed;
                  r_base    <= base_addr;
                  r_addr    <= base_addr;
                  r_count   <= word_count;
                  r_idx     <= '0;
                  r_done    <= 1'b0;
                  r_pass    <= 1'b0;
                  r_tmo_err <= 1'b0;
                  r_err     <= '0;
                  r_first   <= '0;
                  r_busy    <= 1'b1;
                  r_state   <= WAIT_INIT;
               end
            end
            WAIT_INIT, WGAP, RGAP: begin
               if (r_state == WAIT_INIT && r_count == '0) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= 1'b1;
                  r_state <= DONE;
               end else if (r_state != WAIT_INIT || sdr_init_done) begin
                  // r_idx/r_addr already point at the word this burst starts with
                  r_cyc     <= 1'b1;
                  r_we      <= (r_state != RGAP);
                  r_wb_addr <= r_addr;
                  r_dat     <= (r_state != RGAP) ? w_cur_dat : '0;
                  r_cti     <= w_cur_cti;
                  r_sel     <= '1;
                  r_tmo     <= '0;
                  r_state   <= (r_state == RGAP) ? READ : WRITE;
               end
            end
            WRITE, READ: begin
               if (wb.wb_ack_i) begin
                  r_tmo <= '0;
                  if (!r_we) begin
                     r_err <= w_err_nxt;
                     if (w_mismatch && r_err == '0)
                        r_first <= r_addr;
                  end
                  if (w_final) begin
                     r_cyc  <= 1'b0;
                     r_we   <= 1'b0;
                     r_idx  <= '0;
                     r_addr <= r_base;
                     if (r_we) begin
                        r_state <= RGAP;
                     end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == '0);
                        r_state <= DONE;
                     end
                  end else begin
                     r_idx  <= w_nxt_idx;
                     r_addr <= w_nxt_addr;
                     if (r_cti == CTI_END) begin
                        r_cyc   <= 1'b0;
                        r_state <= r_we ? WGAP : RGAP;
                     end else begin
                        r_wb_addr <= w_nxt_addr;
                        r_dat     <= r_we ? w_nxt_dat : '0;
                        r_cti     <= w_nxt_cti;
                     end
                  end
               end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                  r_cyc     <= 1'b0;
                  r_we      <= 1'b0;
                  r_tmo_err <= 1'b1;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_pass    <= 1'b0;
                  r_state   <= DONE;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign wb.wb_cyc_o    = r_cyc;
   assign wb.wb_stb_o    = r_cyc;
   assign wb.wb_we_o     = r_we;
   assign wb.wb_addr_o   = r_wb_addr;
   assign wb.wb_dat_o    = r_dat;
   assign wb.wb_sel_o    = r_sel;
   assign wb.wb_cti_o    = r_cti;
   assign busy           = r_busy;
   assign done           = r_done;
   assign pass           = r_pass;
   assign timeout_err    = r_tmo_err;
   assign err_count      = r_err;
   assign first_err_addr = r_first;
endmodule
